// File: rtl/instr_queue.sv
// Instruction prefetch queue between fetch and decode: a power-of-two circular
// buffer with one-cycle latency, a flush for redirects, and NOP on an empty head.
module instr_queue #(
  parameter int unsigned     WIDTH = 32,
  parameter int unsigned     DEPTH = 4,
  parameter logic [WIDTH-1:0] NOP  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           im_dout,
  output logic                       in_ready,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  // Handshakes look only at registered count, so in_ready never depends on out_ready.
  assign in_ready  = (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);
  assign instr     = out_valid ? mem_q[rd_ptr_q] : NOP;
  assign count     = count_q;

  always_comb begin
    push     = in_valid && in_ready && !flush;
    pop      = out_valid && out_ready && !flush;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap for free because DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; only pointers and count carry meaning.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= im_dout;
  end

endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: directed scenarios plus randomized traffic, all
// compared against a queue-based reference model of the FIFO behaviour.
module tb_instr_queue;
  localparam int          WIDTH = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP_V = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, out_ready;
  logic [WIDTH-1:0]  im_dout;
  logic              in_ready, out_valid;
  logic [WIDTH-1:0]  instr;
  logic [$clog2(DEPTH+1)-1:0] count;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model_q[$];

  instr_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NOP(NOP_V)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .im_dout(im_dout),
    .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid),
    .instr(instr), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge: predict from the model, advance it, then compare all outputs.
  task automatic cycle(input string tag);
    bit       do_push, do_pop;
    logic [31:0] word;
    do_push = !rst && !flush && in_valid && (model_q.size() < DEPTH);
    do_pop  = !rst && !flush && out_ready && (model_q.size() != 0);
    word    = im_dout;
    @(posedge clk);
    #1;
    if (rst || flush) model_q.delete();
    else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(word);
    end
    check({tag, "_count"}, 32'(count), 32'(model_q.size()));
    check({tag, "_ovalid"}, 32'(out_valid), 32'(model_q.size() != 0));
    check({tag, "_iready"}, 32'(in_ready), 32'(model_q.size() < DEPTH));
    check({tag, "_instr"}, instr, (model_q.size() != 0) ? model_q[0] : NOP_V);
  endtask

  task automatic idle();
    rst = 0; flush = 0; in_valid = 0; out_ready = 0; im_dout = '0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cycle("rst"); rst = 0;
  endtask

  task automatic push_word(input logic [31:0] w, input string tag);
    in_valid = 1; im_dout = w; cycle(tag); in_valid = 0;
  endtask

  initial begin
    logic [31:0] seq[4];
    idle();
    #1;
    // Reset state
    do_reset();
    check("reset_count", 32'(count), 32'd0);
    check("reset_instr", instr, NOP_V);
    check("reset_iready", 32'(in_ready), 32'd1);

    // Three pushes, no pops; first push visible one cycle later
    push_word(32'h11, "p11");
    check("lat_instr", instr, 32'h11);
    push_word(32'h22, "p22");
    push_word(32'h33, "p33");
    check("three_count", 32'(count), 32'd3);
    check("three_iready", 32'(in_ready), 32'd1);
    check("three_head", instr, 32'h11);

    // Fill, then pop while 0xFF is offered
    do_reset();
    for (int i = 0; i < 4; i++) push_word(32'hA0 + i, "fill");
    check("full_iready", 32'(in_ready), 32'd0);
    check("full_head", instr, 32'hA0);
    seq = '{32'hA1, 32'hA2, 32'hA3, 32'hFF};
    in_valid = 1; im_dout = 32'hFF; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      cycle("drain");
      check("drain_order", instr, seq[i]);
      if (i == 0) check("full_no_push", 32'(count), 32'd3);
    end
    idle();

    // Streaming push+pop for 10 cycles from count=1
    do_reset();
    push_word(32'h100, "s0");
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      im_dout = 32'h101 + i;
      cycle("stream");
      check("stream_count", 32'(count), 32'd1);
      check("stream_head", instr, 32'h101 + i);
    end
    idle();

    // Flush with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 3; i++) push_word(32'h40 + i, "pf");
    flush = 1; in_valid = 1; im_dout = 32'h55; out_ready = 1;
    cycle("flush");
    check("flush_count", 32'(count), 32'd0);
    check("flush_ovalid", 32'(out_valid), 32'd0);
    check("flush_instr", instr, NOP_V);
    idle();
    for (int i = 0; i < 2; i++) begin
      cycle("postflush");
      check("no_55", 32'(instr == 32'h55), 32'd0);
    end

    // Reset mid-stream with full queue and a pending push
    for (int i = 0; i < 4; i++) push_word(32'hC0 + i, "pr");
    rst = 1; in_valid = 1; im_dout = 32'h77;
    cycle("rstfull");
    check("rstfull_count", 32'(count), 32'd0);
    check("rstfull_instr", instr, NOP_V);
    check("rstfull_iready", 32'(in_ready), 32'd1);
    rst = 0;
    push_word(32'h88, "afterrst");
    check("afterrst_count", 32'(count), 32'd1);
    check("afterrst_instr", instr, 32'h88);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(63) == 0);
      flush     = ($urandom_range(15) == 0);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      im_dout   = $urandom;
      cycle("rand");
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
